// File: rtl/seq_and_checker_pkg.sv
// Shared types and helpers for the seq_and_checker sequence monitor.
// Holds the combine-mode constants and the channel/top state encodings.
package seq_chk_pkg;

    localparam int MODE_AND = 0;
    localparam int MODE_OR  = 1;

    typedef enum logic [1:0] {
        CH_WAIT,
        CH_RUN,
        CH_MATCH,
        CH_FAIL
    } chan_state_e;

    typedef enum logic {
        ST_IDLE,
        ST_CHECK
    } top_state_e;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_and_checker_chan_tracker.sv
// One channel of the checker: waits up to MAX_WAIT low samples, then needs REP
// consecutive high samples. state_adv is the result of sampling ch_bit this cycle.
//
//   state    | meaning
//   CH_WAIT  | run not started, counting low samples in wait_cnt
//   CH_RUN   | run in progress, run_cnt high samples seen so far
//   CH_MATCH | REP consecutive highs seen (terminal until clr)
//   CH_FAIL  | wait budget exhausted or run broken (terminal until clr)
module seq_chan_tracker
    import seq_chk_pkg::*;
#(
    parameter int REP      = 2,
    parameter int MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        ch_bit,
    output chan_state_e state,
    output chan_state_e state_adv
);

    localparam int WW = cnt_w(MAX_WAIT + 1);
    localparam int RW = cnt_w(REP + 1);
    localparam logic [WW-1:0] WAIT_TC = WW'(MAX_WAIT);
    localparam logic [RW-1:0] RUN_TC  = RW'(REP);

    logic [WW-1:0] wait_cnt, wait_adv;
    logic [RW-1:0] run_cnt, run_adv;

    always_comb begin
        state_adv = state;
        wait_adv  = wait_cnt;
        run_adv   = run_cnt;
        case (state)
            CH_WAIT: begin
                if (ch_bit) begin
                    run_adv   = RW'(1);
                    state_adv = (REP == 1) ? CH_MATCH : CH_RUN;
                end else if (wait_cnt == WAIT_TC) begin
                    state_adv = CH_FAIL;
                end else begin
                    wait_adv = wait_cnt + WW'(1);
                end
            end
            CH_RUN: begin
                if (ch_bit) begin
                    run_adv = run_cnt + RW'(1);
                    if (run_adv == RUN_TC) begin
                        state_adv = CH_MATCH;
                    end
                end else begin
                    // No retry after a broken run: first attempt decides.
                    state_adv = CH_FAIL;
                end
            end
            default: begin
                state_adv = state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state    <= CH_WAIT;
            wait_cnt <= '0;
            run_cnt  <= '0;
        end else if (en) begin
            state    <= state_adv;
            wait_cnt <= wait_adv;
            run_cnt  <= run_adv;
        end
    end

endmodule

// File: rtl/seq_and_checker.sv
// Checks "rising start |=> ##[0:MAX_WAIT] ch[i][*REP]" over NCH channels, combined by AND/OR.
// Optional pass/fail statistics counters are built when SEQ_AND_CHECKER_STATS_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | waiting for a rising edge on start; trackers held clear
//   ST_CHECK | trackers sampling ch every cycle until a decision
module seq_and_checker
    import seq_chk_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int REP      = 2,
    parameter int MAX_WAIT = 0,
    parameter int MODE     = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [NCH-1:0]                       ch,
    output logic                                 busy,
    output logic                                 pass,
    output logic                                 fail,
    output logic [NCH-1:0]                       fail_mask,
    output logic [$clog2(MAX_WAIT+REP+1)-1:0]    lat,
    output logic                                 overlap,
    output logic [15:0]                          pass_cnt,
    output logic [15:0]                          fail_cnt
);

    localparam int LW = $clog2(MAX_WAIT + REP + 1);

    top_state_e  st, st_nxt;
    logic        start_q, rose;
    logic [LW-1:0] samp_cnt;
    logic [NCH-1:0] match_v, fail_v;
    logic        pass_d, fail_d, decide;
    logic        trk_clr, trk_en;

    chan_state_e trk_state [NCH];
    chan_state_e trk_adv   [NCH];

    assign rose    = start & ~start_q;
    assign trk_en  = (st == ST_CHECK);
    assign trk_clr = (st == ST_IDLE) | decide;
    assign busy    = trk_en;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        seq_chan_tracker #(
            .REP      (REP),
            .MAX_WAIT (MAX_WAIT)
        ) u_trk (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (trk_clr),
            .en        (trk_en),
            .ch_bit    (ch[g]),
            .state     (trk_state[g]),
            .state_adv (trk_adv[g])
        );

        // Trackers are always parked in WAIT while the checker is idle.
        a_idle_clear: assert property (@(posedge clk) disable iff (!rst_n)
            (st == ST_IDLE) |-> (trk_state[g] == CH_WAIT));
    end

    always_comb begin
        match_v = '0;
        fail_v  = '0;
        for (int i = 0; i < NCH; i++) begin
            match_v[i] = (trk_adv[i] == CH_MATCH);
            fail_v[i]  = (trk_adv[i] == CH_FAIL);
        end
    end

    // AND: any failure aborts early and beats a simultaneous last match.
    always_comb begin
        if (MODE == MODE_OR) begin
            pass_d = |match_v;
            fail_d = &fail_v;
        end else begin
            fail_d = |fail_v;
            pass_d = (&match_v) & ~fail_d;
        end
        decide = trk_en & (pass_d | fail_d);
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE: begin
                if (rose) begin
                    st_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (decide && !rose) begin
                    st_nxt = ST_IDLE;
                end
            end
            default: begin
                st_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // start_q resets high so a start held through reset is not seen as a rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q   <= 1'b1;
            samp_cnt  <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            overlap   <= 1'b0;
            fail_mask <= '0;
            lat       <= '0;
        end else begin
            start_q  <= start;
            samp_cnt <= trk_clr ? '0 : samp_cnt + LW'(1);
            pass     <= decide & pass_d;
            fail     <= decide & fail_d & ~pass_d;
            overlap  <= trk_en & rose & ~decide;
            if (decide) begin
                fail_mask <= fail_v;
                lat       <= samp_cnt + LW'(1);
            end
        end
    end

`ifdef SEQ_AND_CHECKER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            if (pass && pass_cnt != 16'hFFFF) begin
                pass_cnt <= pass_cnt + 16'd1;
            end
            if (fail && fail_cnt != 16'hFFFF) begin
                fail_cnt <= fail_cnt + 16'd1;
            end
        end
    end
`else
    assign pass_cnt = '0;
    assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_and_checker.sv
// Scoreboard bench for seq_and_checker: three instances (MAX_WAIT=0 AND, MAX_WAIT=3 AND,
// MAX_WAIT=3 OR) driven with directed channel patterns; a monitor pops expected results.
module tb_seq_and_checker;
    import seq_chk_pkg::*;

    typedef struct packed {
        logic       is_pass;
        logic [1:0] mask;
        logic [3:0] lat;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = '0;
    logic [1:0] ch_v [3];
    logic [2:0] busy_v, pass_v, fail_v, ovl_v;
    logic [1:0] mask_v [3];
    logic [1:0] lat0;
    logic [2:0] lat1, lat2;
    logic [3:0] lat_x [3];
    logic [15:0] pc [3];
    logic [15:0] fc [3];

    int n_cmp = 0;
    int n_bad = 0;
    res_t q0[$], q1[$], q2[$];

    assign lat_x[0] = {2'b00, lat0};
    assign lat_x[1] = {1'b0, lat1};
    assign lat_x[2] = {1'b0, lat2};

    always #5 clk = ~clk;

    seq_and_checker #(.NCH(2), .REP(2), .MAX_WAIT(0), .MODE(MODE_AND)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .ch(ch_v[0]),
        .busy(busy_v[0]), .pass(pass_v[0]), .fail(fail_v[0]), .fail_mask(mask_v[0]),
        .lat(lat0), .overlap(ovl_v[0]), .pass_cnt(pc[0]), .fail_cnt(fc[0]));

    seq_and_checker #(.NCH(2), .REP(2), .MAX_WAIT(3), .MODE(MODE_AND)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .ch(ch_v[1]),
        .busy(busy_v[1]), .pass(pass_v[1]), .fail(fail_v[1]), .fail_mask(mask_v[1]),
        .lat(lat1), .overlap(ovl_v[1]), .pass_cnt(pc[1]), .fail_cnt(fc[1]));

    seq_and_checker #(.NCH(2), .REP(2), .MAX_WAIT(3), .MODE(MODE_OR)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .ch(ch_v[2]),
        .busy(busy_v[2]), .pass(pass_v[2]), .fail(fail_v[2]), .fail_mask(mask_v[2]),
        .lat(lat2), .overlap(ovl_v[2]), .pass_cnt(pc[2]), .fail_cnt(fc[2]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t mk(input logic p, input logic [1:0] m, input int l);
        res_t r;
        r.is_pass = p;
        r.mask    = m;
        r.lat     = 4'(l);
        return r;
    endfunction

    task automatic push(input int d, input res_t r);
        case (d)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endtask

    // Rise start at E0, then apply vec[2i+:2] at sample E(i+1) for n samples.
    task automatic run_seq(input int d, input logic [15:0] vec, input int n);
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            ch_v[d] = vec[2*i +: 2];
            tick();
        end
        ch_v[d] = 2'b00;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (pass_v[d] || fail_v[d]) begin
                res_t got;
                res_t exp;
                logic empty;
                got.is_pass = pass_v[d];
                got.mask    = mask_v[d];
                got.lat     = lat_x[d];
                check($sformatf("pass_fail_exclusive_dut%0d", d), 32'(pass_v[d] & fail_v[d]), 32'd0);
                empty = 1'b0;
                exp   = '0;
                case (d)
                    0: if (q0.size() == 0) empty = 1'b1; else exp = q0.pop_front();
                    1: if (q1.size() == 0) empty = 1'b1; else exp = q1.pop_front();
                    default: if (q2.size() == 0) empty = 1'b1; else exp = q2.pop_front();
                endcase
                if (empty) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result_dut%0d: got %0h expected none", d, got);
                end else begin
                    check($sformatf("result_dut%0d {pass,mask,lat}", d), 32'(got), 32'(exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 3; d++) ch_v[d] = 2'b00;
        rst_n = 1'b0;
        repeat (2) tick();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_busy_%0d", d), 32'(busy_v[d]), 32'd0);
            check($sformatf("reset_pass_fail_ovl_%0d", d), 32'({pass_v[d], fail_v[d], ovl_v[d]}), 32'd0);
            check($sformatf("reset_mask_lat_%0d", d), 32'({mask_v[d], lat_x[d]}), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // MAX_WAIT=0 AND
        push(0, mk(1'b1, 2'b00, 2)); run_seq(0, 16'h000F, 2); tick();
        check("idle_after_pass", 32'(busy_v[0]), 32'd0);
        push(0, mk(1'b0, 2'b10, 1)); run_seq(0, 16'h0001, 1); tick();
        push(0, mk(1'b0, 2'b01, 2)); run_seq(0, 16'h000B, 2); tick();

        // MAX_WAIT=3 AND
        push(1, mk(1'b1, 2'b00, 4)); run_seq(1, 16'h00A5, 4); tick();
        push(1, mk(1'b0, 2'b10, 2)); run_seq(1, 16'h0007, 2); tick();
        push(1, mk(1'b1, 2'b00, 5)); run_seq(1, 16'h03C0, 5); tick();

        // MAX_WAIT=3 OR
        push(2, mk(1'b1, 2'b00, 3)); run_seq(2, 16'h0028, 3); tick();
        push(2, mk(1'b0, 2'b11, 4)); run_seq(2, 16'h0000, 4); tick();
        push(2, mk(1'b1, 2'b00, 2)); run_seq(2, 16'h0005, 2); tick();

        // Rise while busy on a non-decision edge
        push(1, mk(1'b1, 2'b00, 4));
        start_v[1] = 1'b1; tick();
        start_v[1] = 1'b0; ch_v[1] = 2'b00; tick();
        check("busy_during_check", 32'(busy_v[1]), 32'd1);
        start_v[1] = 1'b1; tick();
        check("overlap_pulse", 32'(ovl_v[1]), 32'd1);
        start_v[1] = 1'b0; ch_v[1] = 2'b11; tick();
        check("overlap_one_cycle", 32'(ovl_v[1]), 32'd0);
        tick();
        ch_v[1] = 2'b00; tick();
        check("idle_after_overlap", 32'(busy_v[1]), 32'd0);

        // Rise on the decision edge relaunches
        push(0, mk(1'b1, 2'b00, 2));
        push(0, mk(1'b1, 2'b00, 2));
        start_v[0] = 1'b1; tick();
        start_v[0] = 1'b0; ch_v[0] = 2'b11; tick();
        start_v[0] = 1'b1; tick();
        check("busy_relaunch", 32'(busy_v[0]), 32'd1);
        check("no_overlap_at_decision", 32'(ovl_v[0]), 32'd0);
        start_v[0] = 1'b0; tick();
        tick();
        ch_v[0] = 2'b00; tick();
        check("idle_after_relaunch", 32'(busy_v[0]), 32'd0);

        // Reset mid-check, start held high through reset
        start_v[0] = 1'b1; tick();
        rst_n = 1'b0; ch_v[0] = 2'b11; tick();
        check("midrst_busy", 32'(busy_v[0]), 32'd0);
        check("midrst_outputs", 32'({pass_v[0], fail_v[0], ovl_v[0], mask_v[0], lat0}), 32'd0);
        rst_n = 1'b1; tick();
        tick();
        check("held_start_no_rise", 32'(busy_v[0]), 32'd0);
        start_v[0] = 1'b0; ch_v[0] = 2'b00; tick();

        // Statistics: three passes then one fail
        for (int k = 0; k < 3; k++) begin
            push(0, mk(1'b1, 2'b00, 2)); run_seq(0, 16'h000F, 2); tick();
        end
        push(0, mk(1'b0, 2'b10, 1)); run_seq(0, 16'h0001, 1); tick();
        tick();
`ifdef SEQ_AND_CHECKER_STATS_EN
        check("pass_cnt", 32'(pc[0]), 32'd3);
        check("fail_cnt", 32'(fc[0]), 32'd1);
`else
        check("pass_cnt_tied", 32'(pc[0]), 32'd0);
        check("fail_cnt_tied", 32'(fc[0]), 32'd0);
`endif

        repeat (3) tick();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
